// File: rtl/bk_adder_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder/subtractor.
// Level counting and register-rank placement live here so bench and RTL agree.
package bk_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    ADDC = 2'b10,
    SUBC = 2'b11
  } bk_op_e;

  localparam int BK_MAX_W = 64;

  function automatic int bk_log2(input int width);
    int l;
    l = 0;
    while ((1 << l) < width) l++;
    return l;
  endfunction

  // Up-sweep of log2 levels plus down-sweep of log2-1 levels.
  function automatic int bk_nlev(input int width);
    return 2 * bk_log2(width) - 1;
  endfunction

  // Prefix level after which register rank k sits: ceil(k*nlev/stages).
  function automatic int bk_cut(input int k, input int stages, input int nlev);
    return (k * nlev + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/bk_adder_pipe_gp_cell.sv
// Brent-Kung black cell: merges a high and a low generate/propagate group.
module bk_gp_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with register ranks spread across the
// prefix tree and an elastic valid/ready chain in which empty ranks always accept.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int L    = bk_log2(WIDTH);
  localparam int N    = 1 << L;
  localparam int NLEV = bk_nlev(WIDTH);

  // Rank number sitting after prefix level lv, or 0 when the level is unregistered.
  function automatic int rank_of(input int lv);
    int r;
    r = 0;
    for (int k = 1; k < STAGES; k++)
      if (bk_cut(k, STAGES, NLEV) == lv) r = k;
    return r;
  endfunction

  // Stage 0: operand conditioning; carry-in folded into bit 0 generate
  logic [WIDTH-1:0] b_p0, p_p0, g_p0;
  logic             c0_p0;

  assign b_p0  = in_op[0] ? ~in_b : in_b;
  assign c0_p0 = in_op[1] ? in_cin : in_op[0];
  assign p_p0  = in_a ^ b_p0;

  always_comb begin
    g_p0    = in_a & b_p0;
    g_p0[0] = g_p0[0] | (p_p0[0] & c0_p0);
  end

  // Valid/ready chain: en[k] means rank k captures this cycle
  logic [STAGES:1]   vld;
  logic [STAGES:1]   vsrc;
  logic [STAGES:1]   ld;
  logic [STAGES+1:1] en;

  always_comb begin
    en[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--)
      en[k] = !vld[k] || en[k+1];
  end

  always_comb begin
    vsrc[1] = in_valid;
    for (int k = 2; k <= STAGES; k++)
      vsrc[k] = vld[k-1];
  end

  assign ld       = en[STAGES:1] & vsrc;
  assign in_ready = en[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (en[k]) vld[k] <= vsrc[k];
    end
  end

  // Prefix tree: level 0 is the per-bit terms padded to a power of two
  for (genvar l = 0; l <= NLEV; l++) begin : g_lvl
    logic [N-1:0]     gq, pq;
    logic [WIDTH-1:0] pb;
    logic             c0;

    if (l == 0) begin : g_in
      assign gq = N'(g_p0);
      assign pq = N'(p_p0);
      assign pb = p_p0;
      assign c0 = c0_p0;
    end else begin : g_net
      logic [N-1:0] gc, pc;

      for (genvar i = 0; i < N; i++) begin : g_bit
        localparam int D   = (l <= L) ? (1 << (l - 1)) : (1 << (2 * L - 1 - l));
        localparam bit ACT = (l <= L) ? (((i + 1) % (2 * D)) == 0)
                                      : ((((i + 1) % (2 * D)) == D) && ((i + 1) > D));
        if (ACT) begin : g_cell
          bk_gp_cell u_cell (
            .gh (g_lvl[l-1].gq[i]),
            .ph (g_lvl[l-1].pq[i]),
            .gl (g_lvl[l-1].gq[i-D]),
            .pl (g_lvl[l-1].pq[i-D]),
            .g  (gc[i]),
            .p  (pc[i])
          );
        end else begin : g_pass
          assign gc[i] = g_lvl[l-1].gq[i];
          assign pc[i] = g_lvl[l-1].pq[i];
        end
      end

      localparam int RK = rank_of(l);
      if (RK != 0) begin : g_rank
        // Rank RK boundary
        always_ff @(posedge clk) begin
          if (ld[RK]) begin
            gq <= gc;
            pq <= pc;
            pb <= g_lvl[l-1].pb;
            c0 <= g_lvl[l-1].c0;
          end
        end
      end else begin : g_wire
        assign gq = gc;
        assign pq = pc;
        assign pb = g_lvl[l-1].pb;
        assign c0 = g_lvl[l-1].c0;
      end
    end
  end

  // Final stage: group generates are the carries out of each bit
  logic [WIDTH-1:0] carry, sum_nx;
  logic             unused_tail;

  assign carry       = g_lvl[NLEV].gq[WIDTH-1:0];
  assign sum_nx      = g_lvl[NLEV].pb ^ {carry[WIDTH-2:0], g_lvl[NLEV].c0};
  assign unused_tail = ^{g_lvl[NLEV].pq, g_lvl[NLEV].gq};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (ld[STAGES]) begin
      out_sum  <= sum_nx;
      out_cout <= carry[WIDTH-1];
      out_ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
    end
  end

  assign out_valid = vld[STAGES];

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed checks on a 32-bit/3-rank adder plus randomised scoreboards on
// several width/rank configurations driven with random valid/ready traffic.
module tb_bk_adder_pipe;
  import bk_pkg::*;

  localparam int TW = 32;
  localparam int TS = 3;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_cin;
  logic [1:0]    in_op;
  logic [TW-1:0] in_a, in_b, out_sum;
  logic          out_valid, out_ready, out_cout, out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bk_adder_pipe #(.WIDTH(TW), .STAGES(TS)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] op, input logic cin);
    logic [63:0] mask, am, bp, sum;
    logic [64:0] full;
    logic        c0, cout, ovf;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bp   = (op[0] ? ~b : b) & mask;
    c0   = op[1] ? cin : op[0];
    full = {1'b0, am} + {1'b0, bp} + 65'(c0);
    sum  = full[63:0] & mask;
    cout = full[w];
    ovf  = (am[w-1] == bp[w-1]) && (sum[w-1] != am[w-1]);
    return {ovf, cout, sum};
  endfunction

  task automatic put(input logic v, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic c);
    in_valid = v;
    in_op    = o;
    in_a     = x;
    in_b     = y;
    in_cin   = c;
  endtask

  logic [1:0]  v_op   [NV] = '{SUB, ADD, ADDC, SUBC, SUB, ADD, SUB};
  logic [31:0] v_a    [NV] = '{32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd10, 32'h80000000, 32'd1, 32'd7};
  logic [31:0] v_b    [NV] = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'd3, 32'd1, 32'd2, 32'd7};
  logic        v_cin  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] v_sum  [NV] = '{32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'd6, 32'h7FFFFFFF, 32'd3, 32'd0};
  logic        v_cout [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        v_ovf  [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Randomised configurations, each with its own reset and scoreboard
  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int W = (c == 0) ? 16 : (c == 1) ? 16 : (c == 2) ? 13 : 64;
    localparam int S = (c == 0) ? 1  : (c == 1) ? 7  : (c == 2) ? 2  : 4;
    logic         r_rst, r_vin, r_rdy_in, r_vout, r_rdy_out, r_cin, r_cout, r_ovf, fin;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b, r_sum;
    logic [65:0]  q[$];
    logic [65:0]  exp_v;

    bk_adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (r_rst),
      .in_valid  (r_vin),
      .in_ready  (r_rdy_in),
      .in_a      (r_a),
      .in_b      (r_b),
      .in_cin    (r_cin),
      .in_op     (r_op),
      .out_valid (r_vout),
      .out_ready (r_rdy_out),
      .out_sum   (r_sum),
      .out_cout  (r_cout),
      .out_ovf   (r_ovf)
    );

    initial begin
      fin = 1'b0; r_rst = 1'b1; r_vin = 1'b0; r_rdy_out = 1'b0;
      r_a = '0; r_b = '0; r_cin = 1'b0; r_op = 2'b00;
      repeat (2) @(negedge clk);
      r_rst = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        r_vin     = (t < 360) && ($urandom_range(0, 3) != 0);
        r_rdy_out = (t >= 360) || ($urandom_range(0, 3) != 0);
        r_a       = W'({$urandom, $urandom});
        r_b       = W'({$urandom, $urandom});
        r_op      = 2'($urandom_range(0, 3));
        r_cin     = 1'($urandom_range(0, 1));
        #1;
        if (r_vout && r_rdy_out) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_ghost", c), 66'(r_vout), 66'(0));
          end else begin
            exp_v = q.pop_front();
            check($sformatf("cfg%0d_result", c), {r_ovf, r_cout, 64'(r_sum)}, exp_v);
          end
        end
        if (r_vin && r_rdy_in) q.push_back(model(W, 64'(r_a), 64'(r_b), r_op, r_cin));
      end
      check($sformatf("cfg%0d_drained", c), 66'(q.size()), 66'(0));
      fin = 1'b1;
    end
  end

  logic all_fin;
  assign all_fin = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin;

  initial begin
    int idx, sent, recv, t_last, leak, stale;

    // Reset state
    rst = 1'b1; out_ready = 1'b0;
    put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 66'(out_valid), 66'(0));
    check("rst_out_data", 66'({out_ovf, out_cout, out_sum}), 66'(0));
    check("rst_in_ready", 66'(in_ready), 66'(1));

    // Latency of one beat: FFFFFFFF + 1
    @(negedge clk);
    out_ready = 1'b1;
    put(1'b1, ADD, 32'hFFFFFFFF, 32'd1, 1'b0);
    #1;
    check("lat_in_ready", 66'(in_ready), 66'(1));
    @(negedge clk);
    put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
    #1;
    check("lat_cycle1", 66'(out_valid), 66'(0));
    @(negedge clk); #1;
    check("lat_cycle2", 66'(out_valid), 66'(0));
    @(negedge clk); #1;
    check("lat_cycle3", 66'(out_valid), 66'(1));
    check("lat_result", 66'({out_ovf, out_cout, out_sum}), {32'd0, 1'b0, 1'b1, 32'h00000000});

    // Directed operation vectors, back to back
    idx = 0;
    for (int t = 0; t < NV + TS + 1; t++) begin
      @(negedge clk);
      if (t < NV) put(1'b1, v_op[t], v_a[t], v_b[t], v_cin[t]);
      else        put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
      #1;
      if (out_valid) begin
        if (idx < NV)
          check($sformatf("vec%0d", idx), 66'({out_ovf, out_cout, out_sum}),
                66'({v_ovf[idx], v_cout[idx], v_sum[idx]}));
        else
          check("vec_extra", 66'(out_valid), 66'(0));
        idx++;
      end
    end
    check("vec_count", 66'(idx), 66'(NV));

    // Back-pressure: 10 beats, out_ready low for cycles 4..8
    sent = 0; recv = 0; t_last = -1; leak = 0;
    for (int t = 0; t < 40 && recv < 10; t++) begin
      @(negedge clk);
      out_ready = !(t >= 4 && t <= 8);
      if (sent < 10) put(1'b1, ADD, 32'h100, 32'(sent), 1'b0);
      else           put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
      #1;
      if (t == 3) check("bp_ready_before", 66'(in_ready), 66'(1));
      if (t == 4) check("bp_ready_fall", 66'(in_ready), 66'(0));
      if (t == 8) check("bp_hold", 66'({out_valid, out_sum}), {33'd0, 1'b1, 32'h101});
      if (t == 9) check("bp_ready_rise", 66'(in_ready), 66'(1));
      if (t >= 4 && t <= 8 && in_ready) leak++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("bp_order", 66'(out_sum), 66'(32'h100 + 32'(recv)));
        recv++;
        t_last = t;
      end
    end
    check("bp_count", 66'(recv), 66'(10));
    check("bp_last_cycle", 66'(t_last), 66'(17));
    check("bp_stall_ready", 66'(leak), 66'(0));

    // Reset with three beats held in flight
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      out_ready = 1'b0;
      put(1'b1, ADD, 32'h1234, 32'(t + 1), 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    put(1'b1, ADD, 32'h55, 32'h55, 1'b0);
    #1;
    check("mid_inflight", 66'({out_valid, out_sum}), {33'd0, 1'b1, 32'h1235});
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
    #1;
    check("mid_out_valid", 66'(out_valid), 66'(0));
    check("mid_out_data", 66'({out_ovf, out_cout, out_sum}), 66'(0));
    check("mid_in_ready", 66'(in_ready), 66'(1));
    stale = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    check("mid_stale", 66'(stale), 66'(0));

    // Traffic resumes after the reset: 100 - 1
    @(negedge clk);
    put(1'b1, SUB, 32'd100, 32'd1, 1'b0);
    @(negedge clk);
    put(1'b0, ADD, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_result", 66'({out_valid, out_ovf, out_cout, out_sum}),
          {31'd0, 1'b1, 1'b0, 1'b1, 32'd99});

    for (int i = 0; i < 3000 && !all_fin; i++) @(negedge clk);
    check("cfg_done", 66'(all_fin), 66'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
